// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: one WIDTH-bit word per valid/ready accept, sent MSB-first with a shift strobe per bit.
// Optional even-parity trailer bit is built when PIPO_PARITY_EN is defined.
module piso_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             shift_out,
  output logic             frame_start,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_reg_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             serial_nxt, shift_out_nxt, frame_start_nxt, busy_nxt;
`ifdef PIPO_PARITY_EN
  logic             parity_bit, parity_bit_nxt;
`endif

  // Handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_ready depends only on state, never on load_valid, and the producer holds data_in until then.
  assign load_ready = (state == IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      serial_out  <= 1'b0;
      shift_out   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
`ifdef PIPO_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_reg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      serial_out  <= serial_nxt;
      shift_out   <= shift_out_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
`ifdef PIPO_PARITY_EN
      parity_bit  <= parity_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    shift_reg_nxt   = shift_reg;
    bit_cnt_nxt     = bit_cnt;
    serial_nxt      = serial_out;
    shift_out_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
    busy_nxt        = busy;
`ifdef PIPO_PARITY_EN
    parity_bit_nxt  = parity_bit;
`endif
    case (state)
      IDLE: begin
        // shift_en is deliberately ignored here so bit 0 never leaves on the accept edge
        if (load_valid) begin
          shift_reg_nxt  = data_in;
          bit_cnt_nxt    = '0;
          busy_nxt       = 1'b1;
          state_nxt      = SHIFT;
`ifdef PIPO_PARITY_EN
          parity_bit_nxt = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          serial_nxt      = shift_reg[WIDTH-1];
          shift_reg_nxt   = {shift_reg[WIDTH-2:0], 1'b0};
          shift_out_nxt   = 1'b1;
          frame_start_nxt = (bit_cnt == '0);
          bit_cnt_nxt     = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef PIPO_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
`endif
          end
        end
      end
`ifdef PIPO_PARITY_EN
      PAR: begin
        if (shift_en) begin
          serial_nxt    = parity_bit;
          shift_out_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: word-level reference model with an expected-word queue and a negedge monitor.
// Build with PIPO_PARITY_EN defined to exercise the parity trailer.
module tb_piso_frame_tx;

  localparam int W = 8;
`ifdef PIPO_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic         shift_en = 1'b0;
  logic         serial_out, shift_out, frame_start, busy;
  logic [1:0]   state_dbg;

  piso_frame_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .serial_out(serial_out),
    .shift_out(shift_out), .frame_start(frame_start), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_strobe = 0;
  int           en_mode = 0;
  logic         busy_m = 1'b0;
  logic         strobe_m = 1'b0;
  logic         serial_m = 1'b0;
  int           rem = 0;
  int           bit_idx = 0;
  logic [W-1:0] cur = '0;
  logic         rx_due = 1'b0;
  logic [W-1:0] rx_word = '0;
  logic [W-1:0] rx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream SISO receiver: shifts serial_out in on each shift_out strobe.
  always @(posedge clk) if (shift_out) rx <= {rx[W-2:0], serial_out};

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    logic busy_before;
    logic exp_bit;
    if (reset) begin
      chk("rst_shift_out", 32'(shift_out), 32'(0));
      chk("rst_serial_out", 32'(serial_out), 32'(0));
      chk("rst_frame_start", 32'(frame_start), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_load_ready", 32'(load_ready), 32'(1));
      exp_q.delete();
      busy_m = 1'b0; strobe_m = 1'b0; serial_m = 1'b0;
      rem = 0; bit_idx = 0; rx_due = 1'b0;
    end else begin
      chk("shift_out", 32'(shift_out), 32'(strobe_m));
      chk("load_ready", 32'(load_ready), 32'(!busy_m));
      chk("busy", 32'(busy), 32'(busy_m));
      if (rx_due) begin
        chk("loopback_rx", 32'(rx), 32'(rx_word));
        rx_due = 1'b0;
      end
      if (strobe_m) begin
        n_strobe++;
        if (bit_idx == 0) begin
          if (exp_q.size() == 0) chk("exp_q_empty", 32'(1), 32'(0));
          else cur = exp_q.pop_front();
        end
        exp_bit  = (bit_idx < W) ? cur[W-1-bit_idx] : ^cur;
        serial_m = exp_bit;
        chk("frame_start", 32'(frame_start), 32'(bit_idx == 0));
        if (bit_idx == W - 1) begin
          rx_due  = 1'b1;
          rx_word = cur;
        end
        bit_idx = (bit_idx == FRAME_LEN - 1) ? 0 : bit_idx + 1;
      end else begin
        chk("frame_start_idle", 32'(frame_start), 32'(0));
      end
      chk("serial_out", 32'(serial_out), 32'(serial_m));
      // Predict the coming edge from the inputs now stable.
      busy_before = busy_m;
      strobe_m = busy_before && shift_en;
      if (strobe_m) begin
        rem--;
        if (rem == 0) busy_m = 1'b0;
      end
      if (load_valid && !busy_before) begin
        exp_q.push_back(data_in);
        rem    = FRAME_LEN;
        busy_m = 1'b1;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (en_mode)
        0:       shift_en = 1'b1;
        1:       shift_en = ~shift_en;
        default: shift_en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_word(input logic [W-1:0] d);
    logic acc;
    int   k;
    data_in    = d;
    load_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      acc = load_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (k == 200) chk("load_timeout", 32'(1), 32'(0));
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!busy_m && exp_q.size() == 0 && !strobe_m && !rx_due) break;
    end
    if (k == 400) chk("idle_timeout", 32'(1), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int k;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed: consecutive strobes, toggled pacing, load held during a frame.
    en_mode = 0; send_word(8'hA5); wait_idle();
    en_mode = 1; send_word(8'hC3); wait_idle();
    en_mode = 0; send_word(8'h81); send_word(8'hFF); wait_idle();

    // Reset after three strobes aborts the frame.
    en_mode = 0;
    start = n_strobe;
    send_word(8'h5A);
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (n_strobe - start >= 3) break;
    end
    if (k == 100) chk("strobe_timeout", 32'(1), 32'(0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_word(8'h0F); wait_idle();

    // Back-to-back loopback words.
    send_word(8'h3C); send_word(8'h96); wait_idle();
`ifdef PIPO_PARITY_EN
    send_word(8'h07); wait_idle();
    send_word(8'h03); wait_idle();
`endif

    // Randomized frames, pacing and gaps.
    for (int i = 0; i < 40; i++) begin
      en_mode = $urandom_range(0, 2);
      send_word(W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
